// File: rtl/fifo_cmd_seq_pkg.sv
// Shared definitions for the FIFO command sequencer, its instruction wrapper and the bench.
// Contents: sequencer state enum, instruction-word layout, op encodings, and an
// instruction-word builder.
package fifo_cmd_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned INST_W = 34;
  localparam int unsigned WE_BIT = 33;
  localparam int unsigned RE_BIT = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic OP_WR = 1'b0;
  localparam logic OP_RD = 1'b1;

  // Instruction word layout: {WE, RE, DI}.
  function automatic logic [INST_W-1:0] mk_inst(input logic we, input logic re,
                                                 input logic [DATA_W-1:0] di);
    return {we, re, di};
  endfunction

endpackage

// File: rtl/fifo_cmd_seq_if.sv
// Burst request/response channel between a requester and fifo_cmd_seq.
// Signals:
//   req_valid  requester -> sequencer  burst request present
//   req_ready  sequencer -> requester  request can be accepted
//   req_op     requester -> sequencer  0 = write burst, 1 = read burst
//   req_len    requester -> sequencer  burst length in words
//   req_seed   requester -> sequencer  first data word of a write burst
//   done       sequencer -> requester  one-cycle pulse at burst end
//   err        sequencer -> requester  qualifies done: rejected request or drain timeout
interface fifo_cmd_seq_if
  import fifo_cmd_seq_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] req_seed;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_op, req_len, req_seed,
    input  req_ready, done, err
  );

  modport slave (
    input  req_valid, req_op, req_len, req_seed,
    output req_ready, done, err
  );

endinterface

// File: rtl/fifo_cmd_seq.sv
// Command sequencer driving the FIFO instruction bus {WE, RE, DI}.
// Accepts write/read burst requests, checks them against a shadow occupancy count, issues
// one command per cycle, and for reads waits (bounded) for the returned read_valid strobes.
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   req         burst request/response channel (slave side)
//   inst        registered instruction word, zero outside WRITE/READ
//   read_valid  FIFO read-data strobe, counted outside IDLE
//   occupancy   shadow count of words held in the FIFO
module fifo_cmd_seq
  import fifo_cmd_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned TIMEOUT = 15,
  localparam int unsigned OCC_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  fifo_cmd_seq_if.slave     req,
  output logic [INST_W-1:0] inst,
  input  logic              read_valid,
  output logic [OCC_W-1:0]  occupancy
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  state_e            state_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;
  logic [LEN_W-1:0]  ret_q;
  logic [DATA_W-1:0] seed_q;
  logic [TMR_W-1:0]  timer_q;

  logic [LEN_W-1:0]  ret_inc;
  logic [OCC_W-1:0]  free_words;
  logic              reject;
  logic              last_cmd;
  logic [DATA_W-1:0] next_di;

  assign req.req_ready = (state_q == StIdle);

  assign ret_inc    = ret_q + LEN_W'(read_valid);
  assign free_words = OCC_W'(DEPTH) - occupancy;
  assign reject     = (req.req_op == OP_WR) ? (32'(req.req_len) > 32'(free_words))
                                            : (32'(req.req_len) > 32'(occupancy));
  assign last_cmd   = (idx_q == len_q - LEN_W'(1));
  // Data word for the command following the current one; wraps at 32 bits.
  assign next_di    = seed_q + 32'(idx_q) + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      len_q     <= '0;
      idx_q     <= '0;
      ret_q     <= '0;
      seed_q    <= '0;
      timer_q   <= '0;
      inst      <= '0;
      occupancy <= '0;
      req.done  <= 1'b0;
      req.err   <= 1'b0;
    end else begin
      req.done <= 1'b0;
      req.err  <= 1'b0;
      // Strobes are counted in every busy state, including the issue phase, so a strobe
      // arriving alongside an RE command is never lost.
      if (state_q != StIdle) ret_q <= ret_inc;

      unique case (state_q)
        StIdle: begin
          if (req.req_valid) begin
            len_q   <= req.req_len;
            seed_q  <= req.req_seed;
            idx_q   <= '0;
            ret_q   <= '0;
            timer_q <= '0;
            if (reject) begin
              state_q  <= StDone;
              req.done <= 1'b1;
              req.err  <= 1'b1;
            end else if (req.req_len == '0) begin
              state_q  <= StDone;
              req.done <= 1'b1;
            end else if (req.req_op == OP_WR) begin
              state_q <= StWrite;
              inst    <= mk_inst(1'b1, 1'b0, req.req_seed);
            end else begin
              state_q <= StRead;
              inst    <= mk_inst(1'b0, 1'b1, '0);
            end
          end
        end

        StWrite: begin
          occupancy <= occupancy + OCC_W'(1);
          if (last_cmd) begin
            state_q  <= StDone;
            inst     <= '0;
            req.done <= 1'b1;
          end else begin
            idx_q <= idx_q + LEN_W'(1);
            inst  <= mk_inst(1'b1, 1'b0, next_di);
          end
        end

        StRead: begin
          occupancy <= occupancy - OCC_W'(1);
          if (last_cmd) begin
            inst <= '0;
            // All data may already be back (zero-latency loopback): skip DRAIN.
            if (ret_inc >= len_q) begin
              state_q  <= StDone;
              req.done <= 1'b1;
            end else begin
              state_q <= StDrain;
              timer_q <= '0;
            end
          end else begin
            idx_q <= idx_q + LEN_W'(1);
          end
        end

        StDrain: begin
          if (ret_inc >= len_q) begin
            state_q  <= StDone;
            req.done <= 1'b1;
          end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            state_q  <= StDone;
            req.done <= 1'b1;
            req.err  <= 1'b1;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
          inst    <= '0;
        end
      endcase
    end
  end

endmodule
